// File: rtl/lcd_sprite_engine.sv
// lcd_sprite_engine
//   Drives a PCD8544-style 84x48 LCD over a byte-wide SPI master. After reset
//   it sends the init command set and then clears the screen. After that it
//   accepts draw requests, which send a sprite from an external ROM clipped to
//   the panel, and clear requests.
// Ports
//   clock, Reset           : system clock, async active-high reset
//   draw_req, clear_req    : one-cycle requests, sampled only when idle
//   erase, pos_x, pos_y    : draw attributes, latched when a draw is accepted
//   spr_addr, spr_data     : sprite ROM read port (combinational ROM)
//   spi_start/dc/data      : byte presented to the SPI master
//   spi_avail              : master consumed the presented byte
//   busy, init_done, done  : status; done is a one-cycle completion pulse
module lcd_sprite_engine #(
  parameter int         SPR_W     = 8,
  parameter int         SPR_PAGES = 1,
  parameter logic [7:0] CONTRAST  = 8'h90,
  parameter int         CLR_BYTES = 504,
  localparam int        AW = (SPR_W * SPR_PAGES > 1) ? $clog2(SPR_W * SPR_PAGES) : 1
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          draw_req,
  input  logic          clear_req,
  input  logic          erase,
  input  logic [6:0]    pos_x,
  input  logic [2:0]    pos_y,
  output logic [AW-1:0] spr_addr,
  input  logic [7:0]    spr_data,
  output logic          spi_start,
  output logic          spi_dc,
  output logic [7:0]    spi_data,
  input  logic          spi_avail,
  output logic          busy,
  output logic          init_done,
  output logic          done
);

  localparam int CW = $clog2(CLR_BYTES + 2) + 1;

  typedef enum logic [2:0] {
    S_INIT, S_CLEAR, S_READY, S_SETX, S_SETY, S_DATA, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]    x, x_n, c, c_n;
  logic [2:0]    y, y_n, p, p_n;
  logic          er, er_n;
  // run is low during reset and the first cycle after release; every SPI
  // output is gated by it so nothing moves until the first clock edge.
  logic          run;
  logic          init_done_q;

  logic [6:0]    vc;
  logic [2:0]    vp;
  logic [15:0]   addr_full;

  // Visible window after clipping against the right/bottom panel edges.
  always_comb begin
    vc = (7'(SPR_W) < (7'd84 - x)) ? 7'(SPR_W) : (7'd84 - x);
    vp = (3'(SPR_PAGES) < (3'd6 - y)) ? 3'(SPR_PAGES) : (3'd6 - y);
    // ROM stride is always the full sprite width, clipped or not.
    addr_full = 16'(p) * 16'(SPR_W) + 16'(c);
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state       <= S_INIT;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      c           <= '0;
      p           <= '0;
      er          <= 1'b0;
      run         <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
      y     <= y_n;
      c     <= c_n;
      p     <= p_n;
      er    <= er_n;
      run   <= 1'b1;
      if (state == S_DONE) init_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x;
    y_n     = y;
    c_n     = c;
    p_n     = p;
    er_n    = er;
    unique case (state)
      S_INIT: if (run && spi_avail) begin
        if (cnt == CW'(3)) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
      end
      // Two address commands, then CLR_BYTES zero data bytes.
      S_CLEAR: if (spi_avail) begin
        if (cnt == CW'(CLR_BYTES + 1)) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
      end
      S_READY: begin
        if (clear_req) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
        end else if (draw_req) begin
          x_n     = pos_x;
          y_n     = pos_y;
          er_n    = erase;
          p_n     = '0;
          c_n     = '0;
          state_n = (pos_x > 7'd83 || pos_y > 3'd5) ? S_DONE : S_SETX;
        end
      end
      S_SETX: if (spi_avail) state_n = S_SETY;
      S_SETY: if (spi_avail) begin
        state_n = S_DATA;
        c_n     = '0;
      end
      S_DATA: if (spi_avail) begin
        if (c == vc - 7'd1) begin
          if (p < vp - 3'd1) begin
            p_n     = p + 3'd1;
            c_n     = '0;
            state_n = S_SETX;
          end else state_n = S_DONE;
        end else c_n = c + 7'd1;
      end
      S_DONE:  state_n = S_READY;
      default: state_n = S_INIT;
    endcase
  end

  always_comb begin
    spi_start = run;
    spi_dc    = 1'b0;
    spi_data  = 8'h00;
    spr_addr  = '0;
    if (run) begin
      unique case (state)
        S_INIT: begin
          unique case (cnt[1:0])
            2'd0:    spi_data = 8'h21;
            2'd1:    spi_data = CONTRAST;
            2'd2:    spi_data = 8'h20;
            default: spi_data = 8'h0C;
          endcase
        end
        S_CLEAR: begin
          if (cnt == CW'(0))      spi_data = 8'h80;
          else if (cnt == CW'(1)) spi_data = 8'h40;
          else                    spi_dc   = 1'b1;
        end
        S_SETX: spi_data = 8'h80 | {1'b0, x};
        S_SETY: spi_data = 8'h40 | {5'b0, y + p};
        S_DATA: begin
          spi_dc   = 1'b1;
          spr_addr = AW'(addr_full);
          spi_data = er ? 8'h00 : spr_data;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_READY);
  assign done      = (state == S_DONE);
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_sprite_engine.sv
module tb_lcd_sprite_engine;
  localparam int SPR_W = 8, SPR_PAGES = 2;

  logic       clock = 1'b0, Reset = 1'b1;
  logic       draw_req = 1'b0, clear_req = 1'b0, erase = 1'b0, spi_avail = 1'b0;
  logic [6:0] pos_x = '0;
  logic [2:0] pos_y = '0;
  logic [3:0] spr_addr;
  logic [7:0] spr_data, spi_data;
  logic       spi_start, spi_dc, busy, init_done, done;

  logic [7:0] rom [16];
  int checks = 0, failures = 0;
  logic [8:0] log_q[$], exp_q[$];
  bit avail_en = 1'b0;
  int ph = 0, done_cnt = 0;

  lcd_sprite_engine #(.SPR_W(SPR_W), .SPR_PAGES(SPR_PAGES), .CONTRAST(8'h90), .CLR_BYTES(504)) dut (
    .clock(clock), .Reset(Reset), .draw_req(draw_req), .clear_req(clear_req),
    .erase(erase), .pos_x(pos_x), .pos_y(pos_y), .spr_addr(spr_addr),
    .spr_data(spr_data), .spi_start(spi_start), .spi_dc(spi_dc),
    .spi_data(spi_data), .spi_avail(spi_avail), .busy(busy),
    .init_done(init_done), .done(done)
  );

  always #5 clock = ~clock;
  assign spr_data = rom[spr_addr];

  // SPI master model: consume a byte every 4 cycles, logging {dc,data}.
  always @(posedge clock) begin
    #1;
    if (avail_en) begin
      ph = ph + 1;
      spi_avail = (ph % 4 == 3);
      if (spi_avail && busy && !done) log_q.push_back({spi_dc, spi_data});
    end else spi_avail = 1'b0;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic wait_done(input int budget, input int start, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt > start) ok = 1'b1;
    end
  endtask

  task automatic pulse_draw(input logic [6:0] x, input logic [2:0] y, input logic er);
    pos_x = x; pos_y = y; erase = er; draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
  endtask

  task automatic check_init_log(input string nm);
    int bad;
    checks++;
    if (log_q.size() !== 510) begin
      failures++; $display("FAIL %s_len got=%0d exp=510", nm, log_q.size());
    end else begin
      exp_q = '{9'h021, 9'h090, 9'h020, 9'h00C, 9'h080, 9'h040};
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL %s_cmd%0d got=%h exp=%h", nm, i, log_q[i], exp_q[i]);
        end
      end
      bad = 0;
      for (int i = 6; i < 510; i++) if (log_q[i] !== 9'h100) bad++;
      checks++;
      if (bad !== 0) begin
        failures++; $display("FAIL %s_zero_data got=%0d_bad exp=0", nm, bad);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({spi_start, spi_dc, spi_data, spr_addr, busy, done, init_done} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b_%h_%h_%b%b%b exp=00_00_0_100",
               spi_start, spi_dc, spi_data, spr_addr, busy, done, init_done);
    end
  endtask

  task automatic test_init();
    bit ok; int s;
    log_q.delete();
    Reset = 1'b0;
    repeat (2) tick();
    avail_en = 1'b1;
    s = done_cnt;
    wait_done(3000, s, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL init_timeout got=0 exp=done"); end
    check_init_log("init");
    tick();
    checks++;
    if ({init_done, busy, done, spi_start} !== 4'b1001) begin
      failures++; $display("FAIL init_status got=%b exp=1001", {init_done, busy, done, spi_start});
    end
  endtask

  task automatic test_draw(input logic [6:0] x, input logic [2:0] y, input int cols, input int pages, input string nm);
    bit ok; int s;
    exp_q.delete();
    for (int pg = 0; pg < pages; pg++) begin
      exp_q.push_back({1'b0, 8'h80 | {1'b0, x}});
      exp_q.push_back({1'b0, 8'h40 | 8'(y + pg)});
      for (int cc = 0; cc < cols; cc++) exp_q.push_back({1'b1, rom[pg * SPR_W + cc]});
    end
    log_q.delete();
    s = done_cnt;
    pulse_draw(x, y, 1'b0);
    wait_done(500, s, ok);
    repeat (10) tick();
    checks++;
    if (!ok || log_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL %s_len got=%0d exp=%0d", nm, log_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL %s_byte%0d got=%h exp=%h", nm, i, log_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done_cnt - s !== 1) begin
      failures++; $display("FAIL %s_done_pulses got=%0d exp=1", nm, done_cnt - s);
    end
  endtask

  task automatic test_offscreen(input logic [6:0] x, input logic [2:0] y, input string nm);
    bit got; int s;
    log_q.delete();
    s = done_cnt;
    got = 1'b0;
    pulse_draw(x, y, 1'b0);
    if (done) got = 1'b1;
    tick();
    if (done) got = 1'b1;
    repeat (8) tick();
    checks++;
    if (got !== 1'b1 || done_cnt - s !== 1) begin
      failures++; $display("FAIL %s_done got=%b/%0d exp=1/1", nm, got, done_cnt - s);
    end
    checks++;
    if (log_q.size() !== 0) begin
      failures++; $display("FAIL %s_bytes got=%0d exp=0", nm, log_q.size());
    end
  endtask

  task automatic test_clear_priority();
    bit ok; int s, bad;
    log_q.delete();
    s = done_cnt;
    pos_x = 7'd10; pos_y = 3'd2; draw_req = 1'b1; clear_req = 1'b1;
    tick();
    draw_req = 1'b0; clear_req = 1'b0;
    repeat (3) tick();
    pulse_draw(7'd0, 3'd0, 1'b0);
    wait_done(3000, s, ok);
    repeat (30) tick();
    checks++;
    if (!ok || log_q.size() !== 506) begin
      failures++; $display("FAIL both_len got=%0d exp=506", log_q.size());
    end else begin
      checks++;
      if (log_q[0] !== 9'h080 || log_q[1] !== 9'h040) begin
        failures++; $display("FAIL both_cmds got=%h,%h exp=080,040", log_q[0], log_q[1]);
      end
      bad = 0;
      for (int i = 2; i < 506; i++) if (log_q[i] !== 9'h100) bad++;
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL both_zero_data got=%0d_bad exp=0", bad); end
    end
    checks++;
    if (done_cnt - s !== 1 || busy !== 1'b0) begin
      failures++; $display("FAIL both_done got=%0d/busy%b exp=1/busy0", done_cnt - s, busy);
    end
  endtask

  task automatic test_erase_reset();
    bit ok; int s;
    log_q.delete();
    s = done_cnt;
    pulse_draw(7'd0, 3'd0, 1'b1);
    erase = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (log_q.size() >= 5) ok = 1'b1; else tick();
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL erase_timeout got=%0d exp=5", log_q.size()); end
    else begin
      checks++;
      if (log_q[0] !== 9'h080 || log_q[1] !== 9'h040 || log_q[2] !== 9'h100 ||
          log_q[3] !== 9'h100 || log_q[4] !== 9'h100) begin
        failures++;
        $display("FAIL erase_bytes got=%h,%h,%h,%h,%h exp=080,040,100,100,100",
                 log_q[0], log_q[1], log_q[2], log_q[3], log_q[4]);
      end
      checks++;
      if (spr_addr !== 4'd2) begin failures++; $display("FAIL erase_addr got=%0d exp=2", spr_addr); end
    end
    // Reset mid-cycle, between clock edges.
    #1 Reset = 1'b1; avail_en = 1'b0;
    #1;
    checks++;
    if ({spi_start, spi_dc, spi_data, spr_addr, busy, done, init_done} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got=%b%b_%h_%h_%b%b%b exp=00_00_0_100",
               spi_start, spi_dc, spi_data, spr_addr, busy, done, init_done);
    end
    repeat (3) tick();
    checks++;
    if (done_cnt !== s) begin failures++; $display("FAIL reset_no_done got=%0d exp=%0d", done_cnt, s); end
    log_q.delete();
    Reset = 1'b0;
    repeat (2) tick();
    avail_en = 1'b1;
    wait_done(3000, s, ok);
    check_init_log("restart");
    tick();
    checks++;
    if (init_done !== 1'b1) begin failures++; $display("FAIL restart_init_done got=%b exp=1", init_done); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'(8'h31 + i * 11);
    test_reset();
    test_init();
    test_draw(7'd10, 3'd2, 8, 2, "draw_10_2");
    test_draw(7'd80, 3'd5, 4, 1, "draw_clip");
    test_offscreen(7'd90, 3'd0, "off_x");
    test_offscreen(7'd0, 3'd6, "off_y");
    test_clear_priority();
    test_erase_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_sprite_engine.md
LCD_SPRITE_ENGINE -- requirements
Module: lcd_sprite_engine

Interface
REQ-001 SHALL have parameter SPR_W, default 8, sprite width in columns (1..84).
REQ-002 SHALL have parameter SPR_PAGES, default 1, sprite height in 8-pixel banks (1..6).
REQ-003 SHALL have parameter CONTRAST, default 8'h90, extended-mode Vop command byte sent during init.
REQ-004 SHALL have parameter CLR_BYTES, default 504, number of zero data bytes sent by a clear.
REQ-005 SHALL have ports: clock  in  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have ports: Reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: draw_req  in  1  one-cycle request to draw the sprite; clear_req  in  1  one-cycle request to blank the screen.
REQ-008 SHALL have ports: erase  in  1  when 1, the accepted draw writes 8'h00 instead of sprite bytes; pos_x  in  7  column 0..83; pos_y  in  3  bank 0..5.
REQ-009 SHALL have ports: spr_addr  out  clog2(SPR_W*SPR_PAGES)  sprite ROM address; spr_data  in  8  ROM byte, combinational, valid in the same cycle.
REQ-010 SHALL have ports: spi_start  out  1  SPI master enable; spi_dc  out  1  0 = command, 1 = display data; spi_data  out  8  byte to transmit.
REQ-011 SHALL have ports: spi_avail  in  1  one-cycle pulse from the SPI master meaning the presented byte has been consumed.
REQ-012 SHALL have ports: busy  out  1  sequence in progress; init_done  out  1  init and first clear complete (sticky); done  out  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states INIT, CLEAR, READY, SETX, SETY, DATA, DONE.
REQ-014 SHALL present each byte on spi_dc/spi_data until the cycle in which spi_avail=1, and SHALL present the next byte on the following cycle.
REQ-015 SHALL hold spi_start=1 in every state after reset.
REQ-016 INIT SHALL send the commands 8'h21, CONTRAST, 8'h20, 8'h0C in order (spi_dc=0), then go to CLEAR.
REQ-017 CLEAR SHALL send 8'h80 and 8'h40 (spi_dc=0), then CLR_BYTES bytes of 8'h00 (spi_dc=1), then go to DONE.
REQ-018 The byte counter in CLEAR SHALL wrap at exactly CLR_BYTES accepted bytes, with no extra bytes.
REQ-019 READY SHALL be the only state that accepts requests; busy=0 only in READY.
REQ-020 If clear_req and draw_req are both 1 in the same READY cycle, the engine SHALL take clear and drop draw.
REQ-021 On draw accept, the engine SHALL latch pos_x, pos_y and erase, clear the page counter p, and go to SETX.
REQ-022 Requests arriving while busy=1 SHALL be ignored, not queued.
REQ-023 Clipping: visible columns VC = min(SPR_W, 84-pos_x); visible pages VP = min(SPR_PAGES, 6-pos_y).
REQ-024 If pos_x>83 or pos_y>5, the draw SHALL send no bytes and go directly to DONE.
REQ-025 SETX SHALL send 8'h80|x (spi_dc=0); SETY SHALL send 8'h40|(y+p) (spi_dc=0); the engine then enters DATA with column c=0.
REQ-026 DATA SHALL drive spr_addr = p*SPR_W + c and spi_data = erase ? 8'h00 : spr_data, with spi_dc=1.
REQ-027 On each accepted byte in DATA, c SHALL increment. At c=VC-1: if p<VP-1, the engine SHALL increment p and go to SETX; otherwise it SHALL go to DONE.
REQ-028 DONE SHALL pulse done=1 for one cycle and go to READY.
REQ-029 init_done SHALL be set on the first DONE after reset.
REQ-030 Column bytes beyond VC SHALL never be sent; spr_addr stride SHALL remain SPR_W regardless of clipping.
REQ-031 spi_avail SHALL be ignored in READY and DONE.

Reset
REQ-032 While Reset=1, the engine SHALL hold: state=INIT, counters=0, spi_start=0, spi_dc=0, spi_data=8'h00, spr_addr=0, busy=1, done=0, init_done=0.
REQ-033 Reset asserted mid-sequence SHALL abort immediately, with no completion pulse.
REQ-034 After Reset falls, the engine SHALL restart the full INIT+CLEAR sequence.
REQ-035 No registered output SHALL glitch on Reset deassertion.

Verification
REQ-036 Reset release with spi_avail pulsed every 4 cycles -> bytes 21,90,20,0C (cmd), then 80,40 (cmd), then 504 x 00 (data); then done pulse, init_done=1, busy=0.
REQ-037 SPR_W=8, SPR_PAGES=2, draw at x=10, y=2 -> cmd 8A, cmd 42, data ROM[0..7], cmd 8A, cmd 43, data ROM[8..15]; then one done pulse.
REQ-038 Draw at x=80, y=5 with SPR_W=8, SPR_PAGES=2 -> cmd D0, cmd 45, data ROM[0..3] only; then done.
REQ-039 Draw with x=90 -> no SPI bytes; done pulses within 2 cycles of the request.
REQ-040 draw_req and clear_req in the same cycle -> clear sequence only; a second draw_req while busy has no effect.
REQ-041 Erase draw at x=0, y=0 -> data bytes all 00; Reset asserted after the 3rd data byte -> outputs reach reset values asynchronously, then INIT restarts.
